// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single instruction/program memory port between
// ICache refill (port 0), DCache refill/store (port 1) and the UART loader (port 2).
// One burst is owned at a time; beats are issued one per cycle, read data is
// returned MEM_LAT cycles later and routed to the owner, then done pulses.
// Build option: define IMEM_ARB_RR_EN for round-robin between ports 0 and 1;
// without it ports 0/1 use fixed priority (1 over 0). Port 2 always wins.
module imem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [11:0]           len,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [2:0]            done,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_DRAIN} state_t;

  localparam logic [3:0]        MAX_B     = 4'(MAX_BURST);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-3:0] WA_ONE    = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [ADDR_W-3:0]   wa_q, wa_d;        // next word address to issue
  logic [3:0]          beats_q, beats_d;  // beats still to issue after the current one
  logic [3:0]          rem_q, rem_d;      // read beats not yet returned to the owner
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MEM_LAT-1:0]  pipe_q, pipe_d;    // read-in-flight tracker, one bit per cycle of latency
  logic [2:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          done_q, done_d;
  logic [2:0]          win;
  logic [ADDR_W-1:0]   sel_addr;
  logic [3:0]          sel_len;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_wdata;
  logic [3:0]          eff_len;
`ifdef IMEM_ARB_RR_EN
  logic                rr_last_q, rr_last_d; // 1: port 1 was served last among ports 0/1
`endif

  // Arbitration: port 2 absolute, then ports 0/1 by round-robin or fixed priority
  always_comb begin
    win = 3'b000;
    if (req[2]) begin
      win = 3'b100;
`ifdef IMEM_ARB_RR_EN
    end else if (req[1] && req[0]) begin
      win = rr_last_q ? 3'b001 : 3'b010;
`endif
    end else if (req[1]) begin
      win = 3'b010;
    end else if (req[0]) begin
      win = 3'b001;
    end
  end

  // Owner's request fields, selected by the registered grant
  always_comb begin
    case (gnt_q)
      3'b010: begin
        sel_addr  = addr[ADDR_W +: ADDR_W];
        sel_len   = len[4 +: 4];
        sel_we    = we[1];
        sel_wdata = wdata[DATA_W +: DATA_W];
      end
      3'b100: begin
        sel_addr  = addr[2*ADDR_W +: ADDR_W];
        sel_len   = len[8 +: 4];
        sel_we    = we[2];
        sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_addr  = addr[0 +: ADDR_W];
        sel_len   = len[0 +: 4];
        sel_we    = we[0];
        sel_wdata = wdata[0 +: DATA_W];
      end
    endcase
    // Writes are always single-beat; zero length means one beat
    if (sel_we || sel_len == 4'd0) eff_len = 4'd1;
    else if (sel_len > MAX_B)      eff_len = MAX_B;
    else                           eff_len = sel_len;
  end

  // Next-state, beat sequencing and read-return routing
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wa_d        = wa_q;
    beats_d     = beats_q;
    rem_d       = rem_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rvalid_d    = 3'b000;
    rdata_d     = rdata_q;
    done_d      = 3'b000;
`ifdef IMEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    pipe_d[0] = mem_en_q & ~mem_we_q;
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    // A read issued MEM_LAT cycles ago has its data on mem_rdata now
    if (pipe_q[MEM_LAT-1]) begin
      rvalid_d = gnt_q;
      rdata_d  = mem_rdata;
      rem_d    = rem_q - 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        // The cycle showing done still carries the old owner's req; skip it
        if (|req && !(|done_q)) begin
          gnt_d   = win;
          state_d = S_GRANT;
`ifdef IMEM_ARB_RR_EN
          if (win[0]) rr_last_d = 1'b0;
          if (win[1]) rr_last_d = 1'b1;
`endif
        end
      end
      S_GRANT: begin
        // Latch the request and put beat 0 on the bus for the first BURST cycle
        mem_en_d    = 1'b1;
        mem_we_d    = sel_we;
        mem_addr_d  = sel_addr & WORD_MASK;
        mem_wdata_d = sel_we ? sel_wdata : mem_wdata_q;
        wa_d        = sel_addr[ADDR_W-1:2] + WA_ONE;
        beats_d     = eff_len - 4'd1;
        rem_d       = sel_we ? 4'd0 : eff_len;
        state_d     = S_BURST;
      end
      S_BURST: begin
        if (beats_q != 4'd0) begin
          mem_en_d   = 1'b1;
          mem_addr_d = {wa_q, 2'b00};
          wa_d       = wa_q + WA_ONE;
          beats_d    = beats_q - 4'd1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rem_q == 4'd0) begin
          done_d  = gnt_q;
          gnt_d   = 3'b000;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight reads
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 3'b000;
      wa_q        <= '0;
      beats_q     <= 4'd0;
      rem_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pipe_q      <= '0;
      rvalid_q    <= 3'b000;
      rdata_q     <= '0;
      done_q      <= 3'b000;
`ifdef IMEM_ARB_RR_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wa_q        <= wa_d;
      beats_q     <= beats_d;
      rem_q       <= rem_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pipe_q      <= pipe_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
`ifdef IMEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each with
// its own memory model. Expected behaviour comes from a timeline model: a burst
// requested in cycle 0 is granted in cycle 1, beat k is on the bus in cycle 2+k,
// read beat k returns in cycle 3+k+MEM_LAT and done follows the last return.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_s       [3];
  logic [2:0]  req_s       [3];
  logic [2:0]  we_s        [3];
  logic [95:0] addr_s      [3];
  logic [11:0] len_s       [3];
  logic [95:0] wdata_s     [3];
  logic [2:0]  gnt_s       [3];
  logic [2:0]  rvalid_s    [3];
  logic [31:0] rdata_s     [3];
  logic [2:0]  done_s      [3];
  logic        busy_s      [3];
  logic        mem_en_s    [3];
  logic        mem_we_s    [3];
  logic [31:0] mem_addr_s  [3];
  logic [31:0] mem_wdata_s [3];
  logic [31:0] mem_rdata_s [3];

  int nvec = 0;
  int nerr = 0;
  int cur_j = 0;
  int last01 [3];   // port (0 or 1) served last, per instance

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [31:0] mpipe [LAT];

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .MEM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst_s[g]),
      .req       (req_s[g]),
      .we        (we_s[g]),
      .addr      (addr_s[g]),
      .len       (len_s[g]),
      .wdata     (wdata_s[g]),
      .gnt       (gnt_s[g]),
      .rvalid    (rvalid_s[g]),
      .rdata     (rdata_s[g]),
      .done      (done_s[g]),
      .busy      (busy_s[g]),
      .mem_en    (mem_en_s[g]),
      .mem_we    (mem_we_s[g]),
      .mem_addr  (mem_addr_s[g]),
      .mem_wdata (mem_wdata_s[g]),
      .mem_rdata (mem_rdata_s[g])
    );

    // Memory with a fixed LAT-cycle read latency; junk when no read is in flight
    always @(posedge clk) begin
      mpipe[0] <= (mem_en_s[g] && !mem_we_s[g]) ? memf(mem_addr_s[g]) : $urandom;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_rdata_s[g] = mpipe[LAT-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, cur_j, obs, exp);
    end
  endtask

  task automatic set_port(input int j, input int p, input logic [31:0] a, input logic [3:0] l,
                          input logic w, input logic [31:0] d);
    addr_s[j][p*32 +: 32]  = a;
    len_s[j][p*4 +: 4]     = l;
    we_s[j][p]             = w;
    wdata_s[j][p*32 +: 32] = d;
  endtask

  function automatic int model_winner(input int j, input logic [2:0] r);
    if (r[2]) return 2;
`ifdef IMEM_ARB_RR_EN
    if (r[1] && r[0]) return (last01[j] == 1) ? 0 : 1;
`endif
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  // One transaction on instance j, entered and left at a negedge
  task automatic run_txn(input int j, input logic [2:0] add_mask, input logic [2:0] late_mask,
                         input bit drop_early);
    logic [2:0]  oh;
    logic [31:0] a, d;
    logic [3:0]  l;
    logic        w;
    int          win, lat, blen, done_c, k;
    cur_j = j;
    lat = j + 1;
    req_s[j] = req_s[j] | add_mask;
    win = model_winner(j, req_s[j]);
    if (win < 0) return;
    if (win < 2) last01[j] = win;
    oh = 3'b001 << win;
    a = addr_s[j][win*32 +: 32];
    l = len_s[j][win*4 +: 4];
    w = we_s[j][win];
    d = wdata_s[j][win*32 +: 32];
    blen = (w || l == 4'd0) ? 1 : ((l > 4'd8) ? 8 : int'(l));
    done_c = w ? 4 : blen + 3 + lat;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("gnt", gnt_s[j], (c < done_c) ? oh : 3'b000);
      chk("busy", busy_s[j], c < done_c);
      chk("mem_en", mem_en_s[j], (c >= 2 && c < 2 + blen));
      if (c >= 2 && c < 2 + blen) begin
        chk("mem_addr", mem_addr_s[j], {a[31:2] + 30'(c - 2), 2'b00});
        chk("mem_we", mem_we_s[j], w);
        if (w) chk("mem_wdata", mem_wdata_s[j], d);
      end
      k = c - 3 - lat;
      if (!w && k >= 0 && k < blen) begin
        chk("rvalid", rvalid_s[j], oh);
        chk("rdata", rdata_s[j], memf({a[31:2] + 30'(k), 2'b00}));
      end else begin
        chk("rvalid_idle", rvalid_s[j], 3'b000);
      end
      chk("done", done_s[j], (c == done_c) ? oh : 3'b000);
      if (c == 2) req_s[j] = req_s[j] | (late_mask & ~oh);
      if ((c == 3 && drop_early) || c == done_c) req_s[j] = req_s[j] & ~oh;
    end
  endtask

  task automatic drain(input int j);
    for (int n = 0; n < 4 && req_s[j] != 3'b000; n++) run_txn(j, 3'b000, 3'b000, 1'b0);
    chk("drained", req_s[j], 3'b000);
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      rst_s[j] = 1'b1; req_s[j] = '0; we_s[j] = '0; addr_s[j] = '0;
      len_s[j] = '0; wdata_s[j] = '0; last01[j] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      cur_j = j;
      chk("rst_gnt", gnt_s[j], 3'b000);
      chk("rst_rvalid", rvalid_s[j], 3'b000);
      chk("rst_done", done_s[j], 3'b000);
      chk("rst_busy", busy_s[j], 1'b0);
      chk("rst_mem_en", mem_en_s[j], 1'b0);
      chk("rst_mem_we", mem_we_s[j], 1'b0);
      chk("rst_mem_addr", mem_addr_s[j], 32'h0);
      chk("rst_mem_wdata", mem_wdata_s[j], 32'h0);
      chk("rst_rdata", rdata_s[j], 32'h0);
      rst_s[j] = 1'b0;
    end

    // ICache 4-beat read from an unaligned base, MEM_LAT=1
    set_port(0, 0, 32'h0000_1006, 4'd4, 1'b0, 32'h0);
    run_txn(0, 3'b001, 3'b000, 1'b0);

    // Ports 0 and 1 together, twice in a row
    set_port(0, 0, 32'h0000_2000, 4'd2, 1'b0, 32'h0);
    set_port(0, 1, 32'h0000_3000, 4'd3, 1'b0, 32'h0);
    run_txn(0, 3'b011, 3'b000, 1'b0);
    run_txn(0, 3'b011, 3'b000, 1'b0);
    drain(0);

    // Port 2 single-beat write beats concurrent port 0/1 requests
    set_port(0, 2, 32'h0000_0020, 4'd5, 1'b1, 32'hDEADBEEF);
    run_txn(0, 3'b111, 3'b000, 1'b0);
    drain(0);

    // Address wrap and length clamp, MEM_LAT=2
    set_port(1, 0, 32'hFFFF_FFF8, 4'd15, 1'b0, 32'h0);
    run_txn(1, 3'b001, 3'b000, 1'b0);

    // Reset during beat 2 of a 4-beat read, MEM_LAT=2
    cur_j = 1;
    set_port(1, 0, 32'h0000_4000, 4'd4, 1'b0, 32'h0);
    req_s[1] = 3'b001;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_gnt", gnt_s[1], 3'b001);
    end
    chk("pre_rst_en", mem_en_s[1], 1'b1);
    chk("pre_rst_addr", mem_addr_s[1], 32'h0000_4008);
    rst_s[1] = 1'b1;
    req_s[1] = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst_s[1] = 1'b0;
    last01[1] = 1;
    chk("post_rst_gnt", gnt_s[1], 3'b000);
    chk("post_rst_busy", busy_s[1], 1'b0);
    chk("post_rst_en", mem_en_s[1], 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_rvalid", rvalid_s[1], 3'b000);
      chk("post_rst_done", done_s[1], 3'b000);
      chk("post_rst_busy_idle", busy_s[1], 1'b0);
    end
    set_port(1, 1, 32'h0000_5004, 4'd3, 1'b0, 32'h0);
    run_txn(1, 3'b010, 3'b000, 1'b0);

    // Zero-length read, MEM_LAT=3
    set_port(2, 1, 32'h0000_0300, 4'd0, 1'b0, 32'h0);
    run_txn(2, 3'b010, 3'b000, 1'b0);

    // Randomised traffic on every instance: late requests, early req drops
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 30; n++) begin
        for (int p = 0; p < 3; p++)
          set_port(j, p, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom);
        run_txn(j, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      drain(j);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
